uart_rx_byte: RTL and testbench

//  UART receive datapath feeding the byte-level consumer: synchronises rx, oversamples,

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_tick.sv | 35 +++
 rtl/uart_rx_byte.sv | 179 +++++++++++++++++
 tb/tb_uart_rx_byte.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot frame states and oversampling helpers.
// Imported by the RX datapath and its baud tick generator.
package uart_pkg;

    localparam int STATE_W = 5;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 5'b00001,
        S_START  = 5'b00010,
        S_DATA   = 5'b00100,
        S_PARITY = 5'b01000,
        S_STOP   = 5'b10000
    } state_t;

    function automatic int mid_idx(input int os);
        return (os / 2) - 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-clock tick every DIV clocks,
// DIV = max(1, CLK_FREQ / (BAUD * OVERSAMPLE)).
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == CW'(DIV - 1));
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_byte.sv
// UART receiver: sync, oversample, deserialise LSB-first, hold byte on valid/ready.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int              OS_W  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [OS_W-1:0] MID   = OS_W'(mid_idx(OVERSAMPLE));
    localparam logic [OS_W-1:0] LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [3:0]      NBITS = 4'(DATA_BITS);

    logic tick;

    uart_baud_tick #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    logic [1:0]           sync_q, sync_d;
    state_t               state_q, state_d;
    logic [OS_W-1:0]      os_q, os_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 ovr_q, ovr_d;
    logic                 rx_s, mid, wrap, stop_mid, par_bad, good;

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    assign par_bad = ^{sh_q, par_q};
`else
    assign par_bad = 1'b0;
`endif

    assign rx_s = sync_q[1];

    // Counter keeps running from START into DATA so every mid tick is mid-bit.
    always_comb begin
        sync_d   = {sync_q[0], rx};
        mid      = tick && (os_q == MID);
        wrap     = tick && (os_q == LAST);
        state_d  = state_q;
        os_d     = os_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        stop_mid = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d    = par_q;
`endif
        if (tick) begin
            os_d = wrap ? '0 : os_q + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                os_d = '0;
                if (tick && !rx_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (mid) begin
                    state_d = rx_s ? S_IDLE : S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (mid) begin
                    sh_d  = {rx_s, sh_q[DATA_BITS-1:1]};
                    bit_d = bit_q + 1'b1;
                end
                if (wrap && bit_q == NBITS) begin
`ifdef UART_RX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (mid) begin
                    par_d = rx_s;
                end
                if (wrap) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (mid) begin
                    stop_mid = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        good    = stop_mid && rx_s && !par_bad;
        data_d  = data_q;
        valid_d = valid_q && !ready;
        ferr_d  = stop_mid && !rx_s;
        perr_d  = stop_mid && rx_s && par_bad;
        ovr_d   = 1'b0;
        if (good) begin
            if (valid_q && !ready) begin
                ovr_d = 1'b1;
            end else begin
                data_d  = sh_q;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b11;
            state_q <= S_IDLE;
            os_q    <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            os_q    <= os_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign frame_err  = ferr_q;
    assign parity_err = perr_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: directed frames plus random frames vs a frame-level model.
// Build with UART_RX_PARITY_EN defined to also exercise the parity bit.
module tb_uart_rx_byte;

    localparam int BAUD     = 115200;
    localparam int OS       = 16;
    localparam int CLK_FREQ = BAUD * OS * 4;
    localparam int BIT      = OS * 4;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       rx    = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid, frame_err, parity_err, overrun, busy;

    int n_chk = 0, n_pass = 0;
    int n_ferr = 0, n_perr = 0, n_ovr = 0, n_vcyc = 0, n_busy = 0, n_bad = 0;
    logic p_ferr = 1'b0, p_perr = 1'b0, p_ovr = 1'b0;
    logic [7:0] got_q[$];

    always #5 clk = ~clk;

    uart_rx_byte #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OS),
        .DATA_BITS (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    // Observes the values that the next rising edge will act on.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (valid && ready) got_q.push_back(data);
            if (valid) n_vcyc++;
            if (busy) n_busy++;
            if (frame_err) n_ferr++;
            if (parity_err) n_perr++;
            if (overrun) n_ovr++;
            if ((frame_err && p_ferr) || (parity_err && p_perr) || (overrun && p_ovr) ||
                (frame_err && parity_err) || (frame_err && overrun) || (parity_err && overrun))
                n_bad++;
        end
        p_ferr = frame_err;
        p_perr = parity_err;
        p_ovr  = overrun;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop_ok, input logic par_ok);
        rx = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clk(BIT);
        end
        if (PAR_EN) begin
            rx = (^b) ^ !par_ok;
            wait_clk(BIT);
        end
        if (stop_ok) begin
            rx = 1'b1;
            wait_clk(BIT);
        end else begin
            rx = 1'b0;
            wait_clk(BIT / 2 + 4);
            rx = 1'b1;
            wait_clk(BIT / 2 - 4);
        end
        rx = 1'b1;
        wait_clk(BIT);
    endtask

    int g0, f0, p0, o0, v0, b0;

    task automatic snap();
        g0 = got_q.size();
        f0 = n_ferr;
        p0 = n_perr;
        o0 = n_ovr;
        v0 = n_vcyc;
        b0 = n_busy;
    endtask

    initial begin
        logic [7:0] b;
        logic       s_ok, p_ok;

        wait_clk(4);
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_pulses", {frame_err, parity_err, overrun}, 3'b000);
        rst = 1'b0;
        wait_clk(BIT);

        snap();
        send(8'h55, 1'b1, 1'b1);
        check("t1_count", got_q.size() - g0, 1);
        check("t1_data", got_q[$], 8'h55);
        check("t1_valid_cycles", n_vcyc - v0, 1);
        check("t1_pulses", (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0), 0);
        check("t1_busy_seen", (n_busy - b0) > 0, 1'b1);
        check("t1_busy_end", busy, 1'b0);

        snap();
        rx = 1'b0;
        wait_clk(12);
        rx = 1'b1;
        wait_clk(2 * BIT);
        check("t2_busy", busy, 1'b0);
        check("t2_valid_cycles", n_vcyc - v0, 0);
        check("t2_pulses", (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0), 0);

        snap();
        send(8'hA3, 1'b0, 1'b1);
        check("t3_ferr", n_ferr - f0, 1);
        check("t3_valid_cycles", n_vcyc - v0, 0);
        send(8'h3C, 1'b1, 1'b1);
        check("t3_next_count", got_q.size() - g0, 1);
        check("t3_next_data", got_q[$], 8'h3C);

        snap();
        ready = 1'b0;
        send(8'h11, 1'b1, 1'b1);
        check("t4_valid", valid, 1'b1);
        check("t4_data", data, 8'h11);
        send(8'h22, 1'b1, 1'b1);
        check("t4_overrun", n_ovr - o0, 1);
        check("t4_data_kept", data, 8'h11);
        check("t4_valid_kept", valid, 1'b1);
        ready = 1'b1;
        wait_clk(2);
        check("t4_valid_clear", valid, 1'b0);
        check("t4_popped", got_q[$], 8'h11);

        snap();
        rx = 1'b0;
        wait_clk(BIT);
        rx = 1'b1;
        wait_clk(BIT);
        rx = 1'b0;
        wait_clk(BIT);
        rx = 1'b0;
        wait_clk(BIT / 2);
        check("t5_busy_mid", busy, 1'b1);
        rst = 1'b1;
        wait_clk(2);
        check("t5_rst_data", data, 8'h00);
        check("t5_rst_valid", valid, 1'b0);
        check("t5_rst_busy", busy, 1'b0);
        rst = 1'b0;
        rx  = 1'b1;
        wait_clk(2 * BIT);
        check("t5_no_pulses", (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0), 0);
        send(8'h5A, 1'b1, 1'b1);
        check("t5_count", got_q.size() - g0, 1);
        check("t5_data", got_q[$], 8'h5A);

`ifdef UART_RX_PARITY_EN
        snap();
        send(8'h07, 1'b1, 1'b0);
        check("t6_perr", n_perr - p0, 1);
        check("t6_drop", got_q.size() - g0, 0);
        send(8'h07, 1'b1, 1'b1);
        check("t6_count", got_q.size() - g0, 1);
        check("t6_data", got_q[$], 8'h07);
`endif

        for (int k = 0; k < 16; k++) begin
            b    = 8'($urandom);
            s_ok = ($urandom_range(0, 3) != 0);
            p_ok = PAR_EN ? ($urandom_range(0, 3) != 0) : 1'b1;
            snap();
            send(b, s_ok, p_ok);
            check("rnd_delivered", got_q.size() - g0, (s_ok && p_ok) ? 1 : 0);
            check("rnd_ferr", n_ferr - f0, s_ok ? 0 : 1);
            check("rnd_perr", n_perr - p0, (s_ok && !p_ok) ? 1 : 0);
            if (s_ok && p_ok && got_q.size() > g0)
                check("rnd_data", got_q[$], b);
        end

        check("pulse_shape", n_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
